// File: rtl/uart_tx_fifo_if.sv
// Byte-write and status bundle between user logic and the buffered UART transmitter.
// The master writes bytes and watches the flow-control flags; the slave drives the line and status.
interface uart_tx_fifo_if;
    logic [7:0] data_in;
    logic       wr_en;
    logic       TX;
    logic       full;
    logic       empty;
    logic       busy;
    logic       overflow;

    modport master (
        output data_in, wr_en,
        input  TX, full, empty, busy, overflow
    );

    modport slave (
        input  data_in, wr_en,
        output TX, full, empty, busy, overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: DEPTH-entry FIFO feeding a start/data/stop serialiser.
// Start bit begins one clock after a write into an idle, empty FIFO; writes while full are dropped and flagged.
module uart_tx_fifo #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 9600,
    parameter int DEPTH  = 4
) (
    input  logic          clk,
    input  logic          res,
    uart_tx_fifo_if.slave bus
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(DEPTH);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          overflow_q, overflow_d;

    logic push, pop, bit_end;

    // Serialiser: every state entry and every bit boundary restarts the baud counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        bit_end = (cnt_q == DIV_LAST);
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (!empty_q) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    tx_d    = shift_q[0];
                    idx_d   = 3'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        shift_d = shift_q >> 1;
                        idx_d   = idx_q + 3'd1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (!empty_q) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Accept decision uses the pre-edge full flag, so a same-cycle pop cannot rescue a write.
    always_comb begin
        push       = bus.wr_en && !full_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = bus.data_in;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        full_d     = (count_d == CNT_FULL);
        empty_d    = (count_d == '0);
        overflow_d = overflow_q || (bus.wr_en && full_q);
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.TX       = tx_q;
    assign bus.busy     = busy_q;
    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at DIV=10, DEPTH=4: reset, single frame, streaming, overflow, mid-frame reset.
module tb_uart_tx_fifo;
    localparam int BIT = 10;

    logic clk = 1'b0;
    logic res = 1'b0;
    always #5 clk = ~clk;

    uart_tx_fifo_if u_if();

    uart_tx_fifo #(.CLK_HZ(1000), .BAUD(100), .DEPTH(4)) dut (
        .clk (clk),
        .res (res),
        .bus (u_if)
    );

    int   checks = 0;
    int   errors = 0;
    logic tx_log   [0:599];
    logic busy_log [0:599];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic capture(input int n);
        for (int t = 0; t < n; t++) begin
            tx_log[t]   = u_if.TX;
            busy_log[t] = u_if.busy;
            step(1);
        end
    endtask

    function automatic int busy_count(input int lo, input int hi);
        int c = 0;
        for (int i = lo; i <= hi; i++) if (busy_log[i] === 1'b1) c++;
        return c;
    endfunction

    function automatic int low_count(input int lo, input int hi);
        int c = 0;
        for (int i = lo; i <= hi; i++) if (tx_log[i] !== 1'b1) c++;
        return c;
    endfunction

    // base = log index of the cycle the start bit begins; sample each bit at its middle.
    task automatic check_frame(input string tag, input int base, input logic [7:0] exp);
        logic [7:0] b;
        int m;
        m = base + BIT / 2;
        for (int k = 0; k < 8; k++) b[k] = tx_log[m + BIT * (k + 1)];
        check({tag, "_start"}, 32'(tx_log[m]), 32'd0);
        check({tag, "_data"}, 32'(b), 32'(exp));
        check({tag, "_stop"}, 32'(tx_log[m + 9 * BIT]), 32'd1);
    endtask

    task automatic pulse_reset();
        res = 1'b0;
        step(2);
        res = 1'b1;
        step(1);
    endtask

    initial begin
        int zeros, bsy;
        u_if.wr_en   = 1'b1;
        u_if.data_in = 8'h5A;
        res          = 1'b0;

        // Reset held with wr_en asserted
        step(5);
        check("rst_tx", 32'(u_if.TX), 32'd1);
        check("rst_empty", 32'(u_if.empty), 32'd1);
        check("rst_full", 32'(u_if.full), 32'd0);
        check("rst_busy", 32'(u_if.busy), 32'd0);
        check("rst_ovf", 32'(u_if.overflow), 32'd0);
        u_if.wr_en = 1'b0;
        res        = 1'b1;
        step(2);
        check("rst_nowrite_empty", 32'(u_if.empty), 32'd1);
        check("rst_nowrite_tx", 32'(u_if.TX), 32'd1);

        // Single byte 0x55
        u_if.wr_en   = 1'b1;
        u_if.data_in = 8'h55;
        step(1);
        u_if.wr_en = 1'b0;
        check("single_empty_low", 32'(u_if.empty), 32'd0);
        check("single_tx_still_idle", 32'(u_if.TX), 32'd1);
        step(1);
        check("single_tx_fall", 32'(u_if.TX), 32'd0);
        check("single_busy_rise", 32'(u_if.busy), 32'd1);
        check("single_empty_again", 32'(u_if.empty), 32'd1);
        capture(110);
        check_frame("single", 0, 8'h55);
        check("single_busy_cycles", 32'(busy_count(0, 109)), 32'd100);
        check("single_tx_idle_after", 32'(tx_log[100]), 32'd1);

        // Back-to-back 0xFF, 0x00, 0xA5 written on consecutive cycles
        u_if.wr_en   = 1'b1;
        u_if.data_in = 8'hFF;
        step(1);
        u_if.data_in = 8'h00;
        step(1);
        u_if.data_in = 8'hA5;
        step(1);
        u_if.wr_en = 1'b0;
        capture(320);
        check_frame("b2b0", -1, 8'hFF);
        check_frame("b2b1", 99, 8'h00);
        check_frame("b2b2", 199, 8'hA5);
        check("b2b_stop_last", 32'(tx_log[98]), 32'd1);
        check("b2b_no_gap", 32'(tx_log[99]), 32'd0);
        check("b2b_busy_cycles", 32'(busy_count(0, 319)), 32'd299);

        // Six writes during IDLE: one popped, four stored, sixth dropped
        u_if.wr_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            u_if.data_in = 8'(8'h11 * (i + 1));
            step(1);
        end
        u_if.wr_en = 1'b0;
        check("ovf_full", 32'(u_if.full), 32'd1);
        check("ovf_flag", 32'(u_if.overflow), 32'd1);
        check("ovf_empty", 32'(u_if.empty), 32'd0);
        capture(520);
        for (int f = 0; f < 5; f++) check_frame($sformatf("ovf%0d", f), 100 * f - 4, 8'(8'h11 * (f + 1)));
        check("ovf_busy_cycles", 32'(busy_count(0, 519)), 32'd496);
        check("ovf_idle_after", 32'(low_count(496, 519)), 32'd0);
        check("ovf_sticky", 32'(u_if.overflow), 32'd1);

        // Write while full on the edge that ends a stop bit and pops
        pulse_reset();
        check("sim_ovf_cleared", 32'(u_if.overflow), 32'd0);
        u_if.wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            u_if.data_in = 8'(8'hA0 + i);
            step(1);
        end
        u_if.wr_en = 1'b0;
        check("sim_full", 32'(u_if.full), 32'd1);
        check("sim_no_ovf_yet", 32'(u_if.overflow), 32'd0);
        step(96);
        u_if.wr_en   = 1'b1;
        u_if.data_in = 8'hEE;
        step(1);
        u_if.wr_en = 1'b0;
        check("sim_ovf_set", 32'(u_if.overflow), 32'd1);
        check("sim_full_drop", 32'(u_if.full), 32'd0);
        check("sim_not_empty", 32'(u_if.empty), 32'd0);
        check("sim_next_start", 32'(u_if.TX), 32'd0);
        capture(420);
        for (int f = 0; f < 4; f++) check_frame($sformatf("sim%0d", f), 100 * f, 8'(8'hA1 + f));
        check("sim_busy_cycles", 32'(busy_count(0, 419)), 32'd400);

        // Reset in the middle of data bit 3 of 0x3C with two bytes queued
        u_if.wr_en = 1'b1;
        u_if.data_in = 8'h3C;
        step(1);
        u_if.data_in = 8'h01;
        step(1);
        u_if.data_in = 8'h02;
        step(1);
        u_if.wr_en = 1'b0;
        step(43);
        check("midrst_busy_before", 32'(u_if.busy), 32'd1);
        check("midrst_bit3", 32'(u_if.TX), 32'd1);
        check("midrst_queued", 32'(u_if.empty), 32'd0);
        #2 res = 1'b0;
        #1;
        check("midrst_tx", 32'(u_if.TX), 32'd1);
        check("midrst_empty", 32'(u_if.empty), 32'd1);
        check("midrst_busy", 32'(u_if.busy), 32'd0);
        check("midrst_full", 32'(u_if.full), 32'd0);
        step(2);
        res = 1'b1;
        zeros = 0;
        bsy   = 0;
        for (int t = 0; t < 300; t++) begin
            step(1);
            if (u_if.TX !== 1'b1) zeros++;
            if (u_if.busy !== 1'b0) bsy++;
        end
        check("midrst_line_idle", 32'(zeros), 32'd0);
        check("midrst_no_frames", 32'(bsy), 32'd0);
        check("midrst_still_empty", 32'(u_if.empty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered UART transmitter: the transmit half of the board's serial link, companion to the existing receiver on the same 50 MHz clock. It accepts bytes from user logic into a small FIFO and serialises them on `TX` as 8N1 frames (1 start, 8 data LSB-first, 1 stop) at a parameterised baud rate. Frames are sent back-to-back while the FIFO holds data; the line idles high otherwise.

## Interface
- `CLK_HZ`, 50_000_000, input clock frequency in Hz
- `BAUD`, 9600, line rate in bit/s; bit period `DIV = CLK_HZ / BAUD` (integer division, truncated; must be ≥ 2)
- `DEPTH`, 4, FIFO entries; power of two, ≥ 2

- `clk`  in  1  system clock, all logic on rising edge
- `res`  in  1  asynchronous active-low reset
- `data_in`  in  8  byte to transmit
- `wr_en`  in  1  write strobe, one byte per cycle
- `TX`  out  1  serial line, registered, idle high
- `full`  out  1  FIFO holds `DEPTH` entries
- `empty`  out  1  FIFO holds 0 entries
- `busy`  out  1  FSM not in IDLE
- `overflow`  out  1  sticky: a write was dropped

## Operation
- Reset (`res` low, asynchronous): `TX`=1, `busy`=0, `full`=0, `empty`=1, `overflow`=0; FIFO pointers/count cleared, FSM to IDLE, counters to 0. Reset mid-frame aborts the frame; `TX` goes high immediately, no partial frame resumes after release.
- Write: `wr_en`=1 and `full`=0 at an edge stores `data_in`. `wr_en`=1 with `full`=1 drops the byte and sets `overflow`; `full` is evaluated on pre-edge state, so a same-cycle pop does not rescue the write. `overflow` clears only on reset.
- FIFO: count width `$clog2(DEPTH)+1`; pointers `$clog2(DEPTH)` bits, wrap naturally. Simultaneous accepted write and pop leave count unchanged.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: `TX`=1. If FIFO non-empty: pop head into shift register, `TX`←0, go START.
  - START: hold `TX`=0 for `DIV` cycles, then `TX`←shift[0], bit index 0, go DATA.
  - DATA: each bit held `DIV` cycles; after bit index 7 completes, `TX`←1, go STOP; else shift right, index+1, `TX`←next bit.
  - STOP: hold `TX`=1 for `DIV` cycles; then if FIFO non-empty pop, `TX`←0, go START (no idle gap); else go IDLE.
- Baud counter counts 0..DIV-1, restarts on every state entry; bit index 3 bits.
- `busy`=1 in START/DATA/STOP.

## Timing
- Write at edge N into empty FIFO with FSM IDLE: `empty` high→low after N; pop and `TX` falls at edge N+1; `empty` returns high after N+1 if no other write.
- Each bit lasts exactly `DIV` clocks; frame = `10*DIV` clocks edge to edge.
- Back-to-back frames: next start bit begins on the edge that ends the previous stop bit; continuous stream = `10*DIV` clocks per byte, zero gap.
- After last frame: `busy` falls on the edge ending the stop bit, simultaneously with IDLE entry.
- `full`, `empty`, `overflow` are registered, valid the cycle after the causing edge.
- Default parameters: `DIV`=5208, bit ≈104.16 µs.

## Test plan
- Reset: hold `res`=0 for 5 cycles with `wr_en`=1 → `TX`=1, `empty`=1, `full`=0, `busy`=0, `overflow`=0; no write accepted.
- Single byte, `CLK_HZ`=1000, `BAUD`=100 (`DIV`=10): write 0x55 → `TX` falls 1 cycle later; sampled mid-bit reads 0,1,0,1,0,1,0,1,0,1; `busy` high for exactly 100 cycles.
- Back-to-back: write 0xFF, 0x00, 0xA5 on consecutive cycles → three frames, 300 cycles total, stop-to-start with no idle cycle, decoded bytes 0xFF, 0x00, 0xA5 in order.
- Full/overflow, `DEPTH`=4: write 6 bytes on consecutive cycles during IDLE → first popped at once, 4 stored, `full`=1, 6th dropped, `overflow`=1; exactly 5 frames transmitted.
- Simultaneous write and pop with FIFO full at stop-bit end → write dropped, `overflow` set, count goes 4→3.
- Reset mid-frame after 3 data bits of 0x3C with 2 bytes queued → `TX`=1 immediately, `empty`=1; after release line stays idle, no further frames.
